// File: rtl/out_port_pkg.sv
// Shared constants, FSM encoding and the double-dabble step for the output port.
// Imported by out_port and its testbench.
package out_port_pkg;

    localparam int BIN_W   = 8;
    localparam int BCD_W   = 12;
    localparam int SHIFT_W = BCD_W + BIN_W;
    localparam int ITERS   = 8;

    typedef enum logic [1:0] {
        OUT_IDLE    = 2'd0,
        OUT_CONVERT = 2'd1,
        OUT_PRESENT = 2'd2
    } out_state_t;

    // One double-dabble iteration: bias every BCD nibble >= 5 by 3, then shift left.
    function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] sr);
        logic [SHIFT_W-1:0] adj;
        adj = sr;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (adj[BIN_W + 4*d +: 4] >= 4'd5)
                adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
        end
        return {adj[SHIFT_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Circular FIFO with wrapping read/write pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module out_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port.sv
// CPU output port: queues emitted values, converts each to 3-digit BCD with a
// sequential double-dabble engine, and presents results on a valid/ready port.
module out_port
    import out_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_in,
    input  logic                   load,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_bin,
    output logic [11:0]            out_bcd,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   full,
    output logic                   overflow,
    output logic [1:0]             fsm_state
);
    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    out_state_t         state;
    out_state_t         next_state;
    logic               pop;
    logic               empty;
    logic [BIN_W-1:0]   head;
    logic [SHIFT_W-1:0] sr;
    logic [SHIFT_W-1:0] step;
    logic [2:0]         iter;
    logic [BIN_W-1:0]   bin_hold;

    out_fifo #(.DEPTH(DEPTH), .W(BIN_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (load),
        .pop   (pop),
        .wdata (data_in),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign step      = dabble_step(sr);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= OUT_IDLE;
        else       state <= next_state;
    end

    // Handshake: out_valid stays high with out_bin/out_bcd frozen until a rising
    // edge sees out_valid && out_ready; that edge completes the transfer.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            OUT_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = OUT_CONVERT;
                end
            end
            OUT_CONVERT: begin
                if (iter == LAST_ITER) next_state = OUT_PRESENT;
            end
            OUT_PRESENT: begin
                if (out_ready) next_state = OUT_IDLE;
            end
            default: next_state = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= '0;
            iter      <= '0;
            bin_hold  <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_bcd   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop) begin
                sr       <= {{BCD_W{1'b0}}, head};
                bin_hold <= head;
                iter     <= '0;
            end
            if (state == OUT_CONVERT) begin
                sr   <= step;
                iter <= iter + 3'd1;
                if (iter == LAST_ITER) begin
                    out_bcd   <= step[SHIFT_W-1:BIN_W];
                    out_bin   <= bin_hold;
                    out_valid <= 1'b1;
                end
            end
            if (state == OUT_PRESENT && out_ready)
                out_valid <= 1'b0;
            // Dropped load: FIFO full and nothing leaving this cycle.
            if (load && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule
